// File: rtl/aes192_sched_if.sv
// aes192_sched_if: requester, datapath and result bundle of the AES-192 block scheduler
interface aes192_sched_if;
    logic         i_key_ready;
    logic [127:0] i_a_din;
    logic         i_a_flag;
    logic         i_a_valid;
    logic         o_a_ready;
    logic [127:0] i_b_din;
    logic         i_b_flag;
    logic         i_b_valid;
    logic         o_b_ready;
    logic [127:0] o_dp_din;
    logic         o_dp_flag;
    logic         o_dp_din_en;
    logic [127:0] i_dp_dout;
    logic         i_dp_dout_en;
    logic [127:0] o_dout;
    logic         o_dout_valid;
    logic         o_dout_id;
    logic         o_busy;
    logic         o_err;
    modport slave (
        input  i_key_ready, i_a_din, i_a_flag, i_a_valid, i_b_din, i_b_flag, i_b_valid, i_dp_dout, i_dp_dout_en,
        output o_a_ready, o_b_ready, o_dp_din, o_dp_flag, o_dp_din_en, o_dout, o_dout_valid, o_dout_id, o_busy, o_err
    );
    modport master (
        output i_key_ready, i_a_din, i_a_flag, i_a_valid, i_b_din, i_b_flag, i_b_valid, i_dp_dout, i_dp_dout_en,
        input  o_a_ready, o_b_ready, o_dp_din, o_dp_flag, o_dp_din_en, o_dout, o_dout_valid, o_dout_id, o_busy, o_err
    );
endinterface

// File: rtl/aes192_sched.sv
// aes192_sched: round-robin scheduler feeding two requesters into a fixed-latency AES-192 datapath
module aes192_sched (
    input logic           i_clk,
    input logic           i_rst,
    aes192_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_b, id, grant_b, hs, at_end;
    // B is granted when it is preferred (A served last) unless only A is valid, or when B alone is valid
    assign grant_b = last_b ? bus.i_b_valid & ~bus.i_a_valid : bus.i_b_valid | ~bus.i_a_valid;
    assign hs      = (bus.o_a_ready & bus.i_a_valid) | (bus.o_b_ready & bus.i_b_valid);
    assign at_end  = state == RUN && cnt == 4'd11;
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (hs ? LOAD : IDLE) :
                    state == LOAD ? RUN :
                    state == RUN  ? (cnt == 4'd11 ? (bus.i_dp_dout_en ? DONE : IDLE) : RUN) : IDLE;
    end
    always_comb begin
        bus.o_a_ready    = state == IDLE && bus.i_key_ready && !i_rst && !grant_b;
        bus.o_b_ready    = state == IDLE && bus.i_key_ready && !i_rst && grant_b;
        bus.o_dp_din_en  = state == LOAD;
        bus.o_dout_valid = state == DONE;
        bus.o_busy       = state != IDLE;
        bus.o_dout_id    = id;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt          <= 4'd0;
            last_b       <= 1'b1;
            id           <= 1'b0;
            bus.o_dp_din <= '0;
            bus.o_dp_flag <= 1'b0;
            bus.o_dout   <= '0;
            bus.o_err    <= 1'b0;
        end else begin
            if (hs) begin
                bus.o_dp_din  <= bus.o_b_ready ? bus.i_b_din : bus.i_a_din;
                bus.o_dp_flag <= bus.o_b_ready ? bus.i_b_flag : bus.i_a_flag;
                id            <= bus.o_b_ready;
                last_b        <= bus.o_b_ready;
            end
            cnt <= state == LOAD ? 4'd1 : state == RUN ? cnt + 4'd1 : 4'd0;
            if (at_end && bus.i_dp_dout_en) bus.o_dout <= bus.i_dp_dout;
            // a strobe off the expected slot, or no strobe in it, are both protocol errors
            if (bus.i_dp_dout_en != at_end) bus.o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes192_sched.sv
// tb_aes192_sched: AES-192 datapath model driving the scheduler with table, random and directed checks
module tb_aes192_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    aes192_sched_if bus ();
    aes192_sched dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

    typedef struct packed {
        bit           va;
        bit           vb;
        logic [127:0] da;
        logic [127:0] db;
        bit           fa;
        bit           fb;
        logic [127:0] exp;
    } vec_t;

    int           n_vec = 0, n_bad = 0, cyc = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [31:0]  w [52];
    logic         last_b_m = 1'b1;
    logic         sup = 1'b0, stray = 1'b0;
    logic [3:0]   d = 4'd0;
    logic [127:0] dp_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0]   inv, s, rc;
        logic [31:0]  t;
        logic [191:0] k;
        k = KEY;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
            isbox[s] = 8'(x);
        end
        rc = 8'h01;
        for (int i = 0; i < 52; i++) begin
            if (i < 6) w[i] = k[191-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % 6 == 0) begin
                    t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end
                w[i] = w[i-6] ^ t;
            end
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int b);
        return s[127-8*b -: 8];
    endfunction

    function automatic logic [127:0] rk(input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv ? isbox[gb(s, b)] : sbox[gb(s, b)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gb(s, 4*((inv ? c - r + 4 : c + r) % 4) + r);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(m[(k - r + 4) % 4], gb(s, 4*c + k));
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] aes(input logic [127:0] din, input bit enc);
        logic [127:0] s;
        if (enc) begin
            s = din ^ rk(0);
            for (int r = 1; r < 12; r++) s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk(r);
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk(12);
        end else begin
            s = din ^ rk(12);
            for (int r = 11; r > 0; r--) s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk(r), 1'b1);
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk(0);
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // datapath: result strobe lands 11 cycles after the start pulse, i.e. at T+12
    always @(negedge clk) begin
        if (rst) d <= 4'd0;
        else if (bus.o_dp_din_en) begin
            d      <= 4'd12;
            dp_res <= aes(bus.o_dp_din, bus.o_dp_flag);
        end else if (d != 4'd0) d <= d - 4'd1;
    end
    assign bus.i_dp_dout_en = (d == 4'd1 && !sup) || stray;
    assign bus.i_dp_dout    = dp_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_b_m = 1'b1;
    endtask

    task automatic wait_hs(output int t);
        t = 0;
        #1;
        while (!((bus.o_a_ready && bus.i_a_valid) || (bus.o_b_ready && bus.i_b_valid)) && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) fail_now("hs_timeout");
    endtask

    task automatic run_one(input bit va, input bit vb, input logic [127:0] da, input logic [127:0] db,
                           input bit fa, input bit fb, input bit keep, input bit drop_key,
                           input bit use_model, input logic [127:0] exp_fixed,
                           output int hs_cyc, output int wait_n, output bit won_b);
        bit           ok, wf;
        logic [127:0] wd, exp;
        bus.i_a_valid = va;
        bus.i_b_valid = vb;
        bus.i_a_din   = da;
        bus.i_b_din   = db;
        bus.i_a_flag  = fa;
        bus.i_b_flag  = fb;
        won_b = (va && vb) ? !last_b_m : vb;
        wait_hs(wait_n);
        hs_cyc = cyc;
        if (wait_n >= 40) begin
            bus.i_a_valid = 1'b0;
            bus.i_b_valid = 1'b0;
            return;
        end
        chk("grant", {bus.o_a_ready, bus.o_b_ready}, won_b ? 2'b01 : 2'b10);
        last_b_m = won_b;
        wd  = won_b ? db : da;
        wf  = won_b ? fb : fa;
        exp = use_model ? aes(wd, wf) : exp_fixed;
        tick();
        if (!keep) begin
            bus.i_a_valid = 1'b0;
            bus.i_b_valid = 1'b0;
        end
        if (drop_key) bus.i_key_ready = 1'b0;
        chk("din_en", bus.o_dp_din_en, 1'b1);
        chk("dp_din", bus.o_dp_din, wd);
        chk("dp_flag", bus.o_dp_flag, wf);
        ok = 1'b1;
        for (int i = 2; i <= 12; i++) begin
            tick();
            if (bus.o_dout_valid || bus.o_dp_din_en || bus.o_a_ready || bus.o_b_ready || !bus.o_busy ||
                bus.o_dp_din !== wd || bus.o_dp_flag !== wf) ok = 1'b0;
        end
        chk("in_flight", ok, 1'b1);
        tick();
        bus.i_key_ready = 1'b1;
        chk("done_valid", bus.o_dout_valid, 1'b1);
        chk("dout", bus.o_dout, exp);
        chk("dout_id", bus.o_dout_id, won_b);
        tick();
        chk("idle_after", {bus.o_dout_valid, bus.o_busy}, 2'b00);
        chk("dout_hold", bus.o_dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   hc, wn, hprev, t;
        bit   wb, ok, va, vb;
        logic [3:0] order;
        tbl[0] = '{1'b1, 1'b0, PT, 128'h0, 1'b1, 1'b0, CT};
        tbl[1] = '{1'b0, 1'b1, 128'h0, CT, 1'b0, 1'b0, PT};
        tbl[2] = '{1'b0, 1'b1, 128'h0, PT, 1'b0, 1'b1, CT};
        tbl[3] = '{1'b1, 1'b0, CT, 128'h0, 1'b0, 1'b0, PT};
        tbl[4] = '{1'b1, 1'b1, PT, CT, 1'b1, 1'b0, PT};
        tbl[5] = '{1'b1, 1'b1, PT, CT, 1'b1, 1'b0, CT};
        rst = 1'b1;
        bus.i_key_ready = 1'b1;
        bus.i_a_valid = 1'b1;
        bus.i_b_valid = 1'b0;
        bus.i_a_din = '0;
        bus.i_b_din = '0;
        bus.i_a_flag = 1'b0;
        bus.i_b_flag = 1'b0;
        build_tables();
        chk("model_enc", aes(PT, 1'b1), CT);
        chk("model_dec", aes(CT, 1'b0), PT);
        #1;
        chk("ready_in_reset", {bus.o_a_ready, bus.o_b_ready}, 2'b00);
        tick();
        chk("ready_in_reset2", {bus.o_a_ready, bus.o_b_ready}, 2'b00);
        bus.i_a_valid = 1'b0;
        do_reset();
        #1;
        chk("rst_ctrl", {bus.o_dp_flag, bus.o_dp_din_en, bus.o_dout_valid, bus.o_dout_id, bus.o_busy, bus.o_err}, 6'b0);
        chk("rst_dp_din", bus.o_dp_din, 128'h0);
        chk("rst_dout", bus.o_dout, 128'h0);
        for (int i = 0; i < 6; i++)
            run_one(tbl[i].va, tbl[i].vb, tbl[i].da, tbl[i].db, tbl[i].fa, tbl[i].fb,
                    1'b0, 1'b0, 1'b0, tbl[i].exp, hc, wn, wb);
        // contention: both requesters stay valid from reset onward
        bus.i_a_valid = 1'b1;
        bus.i_b_valid = 1'b1;
        do_reset();
        hprev = 0;
        order = 4'b0;
        for (int i = 0; i < 4; i++) begin
            run_one(1'b1, 1'b1, rand128(), rand128(), 1'($urandom), 1'($urandom),
                    1'b1, 1'b0, 1'b1, '0, hc, wn, wb);
            order[i] = wb;
            if (i > 0) chk("hs_spacing", hc - hprev, 14);
            hprev = hc;
        end
        chk("grant_order", order, 4'b1010);
        bus.i_a_valid = 1'b0;
        bus.i_b_valid = 1'b0;
        tick();
        bus.i_key_ready = 1'b0;
        bus.i_a_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_a_ready || bus.o_b_ready) ok = 1'b0;
        end
        chk("keygate_no_ready", ok, 1'b1);
        bus.i_key_ready = 1'b1;
        run_one(1'b1, 1'b0, PT, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CT, hc, wn, wb);
        chk("keygate_hs_wait", wn, 0);
        for (int i = 0; i < 12; i++) begin
            va = 1'($urandom);
            vb = 1'($urandom);
            if (!va && !vb) va = 1'b1;
            run_one(va, vb, rand128(), rand128(), 1'($urandom), 1'($urandom),
                    1'b0, 1'($urandom), 1'b1, '0, hc, wn, wb);
        end
        // missing strobe at T+12
        do_reset();
        chk("err_clear", bus.o_err, 1'b0);
        sup = 1'b1;
        bus.i_a_din = PT;
        bus.i_a_flag = 1'b1;
        bus.i_a_valid = 1'b1;
        wait_hs(t);
        tick();
        bus.i_a_valid = 1'b0;
        ok = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (bus.o_dout_valid || bus.o_err) ok = 1'b0;
            tick();
        end
        chk("miss_before", ok, 1'b1);
        chk("miss_err", bus.o_err, 1'b1);
        chk("miss_no_valid", {bus.o_dout_valid, bus.o_busy}, 2'b00);
        tick();
        chk("miss_no_valid_late", bus.o_dout_valid, 1'b0);
        sup = 1'b0;
        // stray strobe while idle
        do_reset();
        chk("err_clear2", bus.o_err, 1'b0);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_err", bus.o_err, 1'b1);
        chk("stray_ignored", {bus.o_dout_valid, bus.o_busy}, 2'b00);
        chk("stray_dout", bus.o_dout, 128'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", bus.o_err, 1'b1);
        // reset while a block is in flight
        do_reset();
        run_one(1'b0, 1'b1, '0, CT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PT, hc, wn, wb);
        bus.i_a_din = PT;
        bus.i_a_flag = 1'b1;
        bus.i_a_valid = 1'b1;
        wait_hs(t);
        tick();
        bus.i_a_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_b_m = 1'b1;
        chk("midrst_ctrl", {bus.o_dp_flag, bus.o_dp_din_en, bus.o_dout_valid, bus.o_dout_id, bus.o_busy, bus.o_err}, 6'b0);
        chk("midrst_dp_din", bus.o_dp_din, 128'h0);
        chk("midrst_dout", bus.o_dout, 128'h0);
        ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.o_dout_valid || bus.o_err) ok = 1'b0;
        end
        chk("midrst_quiet", ok, 1'b1);
        run_one(1'b1, 1'b0, PT, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CT, hc, wn, wb);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
